// File: rtl/anim_scheduler.sv
// Animation step scheduler: on each time tick walks every channel, moves active
// channels one linear step toward their target using a shared restoring divider,
// then hands the frame to the LED shift-out engine and waits for it to finish.
module anim_scheduler #(
    parameter int  c_freq        = 20000000,
    parameter int  c_tick_cycles = 2000000,
    parameter int  c_channels    = 12,
    parameter int  c_bpc         = 12,
    parameter int  c_max_time    = 11,
    localparam int c_time_w      = $clog2(c_max_time),
    localparam int c_chan_w      = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    input  logic [c_chan_w-1:0] i_cmd_chan,
    input  logic [c_bpc-1:0]    i_cmd_target,
    input  logic [c_time_w-1:0] i_cmd_time,
    output logic                o_cmd_ready,
    input  logic [c_chan_w-1:0] i_rd_chan,
    output logic [c_bpc-1:0]    o_rd_data,
    output logic                o_frame_start,
    input  logic                i_frame_done,
    output logic [c_time_w-1:0] o_time,
    output logic                o_overrun
);
    localparam int c_tick_w = $clog2(c_tick_cycles);
    localparam int c_div_w  = $clog2(c_bpc);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_tick_cycles - 1);
    localparam logic [c_chan_w-1:0] c_chan_last = c_chan_w'(c_channels - 1);
    localparam logic [c_time_w-1:0] c_time_last = c_time_w'(c_max_time - 1);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_bpc - 1);

    // A frame must fit inside one tick period, and the clock must be real.
    if (c_tick_cycles <= c_channels * (c_bpc + 2) || c_freq <= 0) begin : g_bad_params
        $error("anim_scheduler: c_tick_cycles too small for one frame");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE, S_SHIFT, S_WAIT} state_t;

    state_t                             state;
    logic [c_channels-1:0][c_bpc-1:0]   cur;
    logic [c_channels-1:0][c_bpc-1:0]   tgt;
    logic [c_channels-1:0][c_time_w-1:0] tt;
    logic [c_channels-1:0]              act;
    logic [c_chan_w-1:0]                idx;
    logic [c_tick_w-1:0]                tick_cnt;
    logic                               tick, tick_pending, cmd_fire, frame_go;

    // divider / per-channel step context
    logic [c_time_w-1:0] dv;       // remaining time steps (divisor)
    logic [c_time_w-1:0] acc_r;    // partial remainder
    logic [c_bpc-1:0]    acc_q;    // dividend shifting out, quotient shifting in
    logic [c_div_w-1:0]  dcnt;
    logic                neg, skip, snap;

    logic [c_bpc-1:0]    cur_k, tgt_k, step_val, mag_c;
    logic [c_time_w-1:0] tt_k, rem_c, nxt_r;
    logic [c_time_w:0]   sh;
    logic                neg_c, ge;

    assign tick     = (tick_cnt == c_tick_last);
    assign cmd_fire = (state == S_IDLE) && i_cmd_valid;
    // a pending tick waits one cycle if a command is being accepted
    assign frame_go = (state == S_IDLE) && !i_cmd_valid && tick_pending;

    // Channel-k arithmetic: remaining time, step magnitude, one divider step
    always_comb begin
        cur_k = cur[idx];
        tgt_k = tgt[idx];
        tt_k  = tt[idx];
        // modular subtraction wraps correctly in c_time_w bits; result < c_max_time
        if (tt_k < o_time) rem_c = c_time_w'(c_max_time) - o_time + tt_k;
        else               rem_c = tt_k - o_time;
        neg_c    = (tgt_k < cur_k);
        mag_c    = neg_c ? (cur_k - tgt_k) : (tgt_k - cur_k);
        sh       = {acc_r, acc_q[c_bpc-1]};
        ge       = (sh >= {1'b0, dv});
        nxt_r    = ge ? c_time_w'(sh - {1'b0, dv}) : sh[c_time_w-1:0];
        step_val = neg ? (cur_k - acc_q) : (cur_k + acc_q);
    end

    // Free-running animation tick counter
    always_ff @(posedge i_clk) begin
        if (i_rst)      tick_cnt <= '0;
        else if (tick)  tick_cnt <= '0;
        else            tick_cnt <= tick_cnt + 1'b1;
    end

    // Registered read port for the shift-out engine
    always_ff @(posedge i_clk) begin
        if (i_rst)                        o_rd_data <= '0;
        else if (i_rd_chan <= c_chan_last) o_rd_data <= cur[i_rd_chan];
        else                              o_rd_data <= '0;
    end

    // Scheduler FSM, tick bookkeeping and channel store
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            cur           <= '0;
            tgt           <= '0;
            tt            <= '0;
            act           <= '0;
            idx           <= '0;
            o_time        <= '0;
            o_cmd_ready   <= 1'b1;
            o_frame_start <= 1'b0;
            o_overrun     <= 1'b0;
            tick_pending  <= 1'b0;
            dv            <= '0;
            acc_r         <= '0;
            acc_q         <= '0;
            dcnt          <= '0;
            neg           <= 1'b0;
            skip          <= 1'b0;
            snap          <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            // only one tick is ever remembered; a second one is reported as lost
            tick_pending  <= tick | (tick_pending & ~frame_go);
            o_overrun     <= tick & tick_pending & ~frame_go;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (i_cmd_chan <= c_chan_last) begin
                            tgt[i_cmd_chan] <= i_cmd_target;
                            tt[i_cmd_chan]  <= i_cmd_time;
                            act[i_cmd_chan] <= 1'b1;
                        end
                    end else if (tick_pending) begin
                        o_time      <= (o_time == c_time_last) ? '0 : o_time + 1'b1;
                        idx         <= '0;
                        o_cmd_ready <= 1'b0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    skip  <= !act[idx];
                    snap  <= (rem_c == '0) || (tgt_k == cur_k);
                    dv    <= rem_c;
                    neg   <= neg_c;
                    acc_q <= mag_c;
                    acc_r <= '0;
                    dcnt  <= '0;
                    if (act[idx] && rem_c != '0 && tgt_k != cur_k) state <= S_DIV;
                    else                                              state <= S_WRITE;
                end
                S_DIV: begin
                    acc_r <= nxt_r;
                    acc_q <= {acc_q[c_bpc-2:0], ge};
                    dcnt  <= dcnt + 1'b1;
                    if (dcnt == c_div_last) state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!skip) begin
                        // final step lands exactly on target, absorbing truncation error
                        if (snap || dv == c_time_w'(1)) begin
                            cur[idx] <= tgt_k;
                            act[idx] <= 1'b0;
                        end else begin
                            cur[idx] <= step_val;
                        end
                    end
                    if (idx == c_chan_last) begin
                        o_frame_start <= 1'b1;
                        state         <= S_SHIFT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_SHIFT: state <= S_WAIT;
                S_WAIT: begin
                    if (i_frame_done) begin
                        o_cmd_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_anim_scheduler.sv
// Directed bench for anim_scheduler with a short tick period and a simple
// shift-out engine model that acknowledges frames (optionally held off).
module tb_anim_scheduler;
    localparam int TICK = 300;
    localparam int CW   = 4;
    localparam int TW   = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [CW-1:0] i_cmd_chan = '0;
    logic [11:0]   i_cmd_target = '0;
    logic [TW-1:0] i_cmd_time = '0;
    logic          o_cmd_ready;
    logic [CW-1:0] i_rd_chan = '0;
    logic [11:0]   o_rd_data;
    logic          o_frame_start;
    logic          i_frame_done = 1'b0;
    logic [TW-1:0] o_time;
    logic          o_overrun;

    int   n_checks = 0;
    int   n_fail = 0;
    int   fs_cnt = 0;
    int   ovr_cnt = 0;
    logic hold = 1'b0;
    int   dn_exp[5] = '{52, 38, 24, 10, 10};

    always #5 clk = ~clk;

    anim_scheduler #(.c_tick_cycles(TICK)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd_chan(i_cmd_chan),
        .i_cmd_target(i_cmd_target), .i_cmd_time(i_cmd_time), .o_cmd_ready(o_cmd_ready),
        .i_rd_chan(i_rd_chan), .o_rd_data(o_rd_data), .o_frame_start(o_frame_start),
        .i_frame_done(i_frame_done), .o_time(o_time), .o_overrun(o_overrun)
    );

    // pulse counters
    always @(negedge clk) begin
        if (o_frame_start) fs_cnt++;
        if (o_overrun) ovr_cnt++;
    end

    // shift-out engine model
    initial forever begin
        @(negedge clk);
        if (o_frame_start) begin
            repeat (4) @(negedge clk);
            while (hold) @(negedge clk);
            i_frame_done = 1'b1;
            @(negedge clk);
            i_frame_done = 1'b0;
        end
    end

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_frame_start && n < 2 * TICK + 200);
        n_checks++;
        if (o_frame_start !== 1'b1) begin
            $display("FAIL %s: frame_start got %b after %0d cycles, want 1", tag, o_frame_start, n);
            n_fail++;
        end
    endtask

    task automatic read_chan(input int ch, output logic [11:0] v);
        @(negedge clk);
        i_rd_chan = CW'(ch);
        @(negedge clk);
        v = o_rd_data;
    endtask

    task automatic send_cmd(input int ch, input int tgt, input int tm);
        int n = 0;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_chan = CW'(ch); i_cmd_target = 12'(tgt); i_cmd_time = TW'(tm);
        while (!o_cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin
            $display("FAIL cmd_accept ch%0d: ready %b, want 1", ch, o_cmd_ready);
            n_fail++;
        end
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_cmd_ready, o_frame_start, o_overrun, o_rd_data, o_time} !== {3'b100, 12'd0, 4'd0}) begin
            $display("FAIL reset_outputs: got rdy=%b fs=%b ovr=%b rd=%0d t=%0d, want 1 0 0 0 0",
                     o_cmd_ready, o_frame_start, o_overrun, o_rd_data, o_time);
            n_fail++;
        end
    endtask

    task automatic test_snap_setup();
        logic [11:0] v;
        int exp[4] = '{10, 80, 10, 0};
        send_cmd(0, 10, 1);
        send_cmd(1, 80, 1);
        send_cmd(2, 10, 1);
        wait_frame("setup");
        n_checks++;
        if (o_time !== 4'd1) begin
            $display("FAIL setup_time: got %0d, want 1", o_time); n_fail++;
        end
        for (int c = 0; c < 4; c++) begin
            read_chan(c, v);
            n_checks++;
            if (v !== 12'(exp[c])) begin
                $display("FAIL setup_ch%0d: got %0d, want %0d", c, v, exp[c]); n_fail++;
            end
        end
        for (int i = 0; i < 3; i++) wait_frame("idle_frames");
        n_checks++;
        if (o_time !== 4'd4) begin
            $display("FAIL idle_time: got %0d, want 4", o_time); n_fail++;
        end
        send_cmd(0, 80, 10);
        send_cmd(1, 10, 10);
        send_cmd(2, 80, 4);
    endtask

    task automatic test_up_wrap();
        logic [11:0] v0, v1, v2;
        int f0 = fs_cnt;
        wait_frame("up_wrap");
        n_checks++;
        if (o_time !== 4'd5) begin
            $display("FAIL up_time: got %0d, want 5", o_time); n_fail++;
        end
        read_chan(0, v0);
        read_chan(2, v2);
        read_chan(1, v1);
        n_checks++;
        if (v0 !== 12'd24) begin $display("FAIL up_ramp: got %0d, want 24", v0); n_fail++; end
        n_checks++;
        if (v2 !== 12'd17) begin $display("FAIL wrap_ramp: got %0d, want 17", v2); n_fail++; end
        n_checks++;
        if (v1 !== 12'd66) begin $display("FAIL down_first: got %0d, want 66", v1); n_fail++; end
        repeat (10) @(negedge clk);
        n_checks++;
        if (fs_cnt - f0 !== 1) begin
            $display("FAIL fs_once: got %0d pulses, want 1", fs_cnt - f0); n_fail++;
        end
    endtask

    task automatic test_down_ramp();
        logic [11:0] v;
        for (int i = 0; i < 5; i++) begin
            wait_frame("down");
            n_checks++;
            if (o_time !== TW'(6 + i)) begin
                $display("FAIL down_time%0d: got %0d, want %0d", i, o_time, 6 + i); n_fail++;
            end
            read_chan(1, v);
            n_checks++;
            if (v !== 12'(dn_exp[i])) begin
                $display("FAIL down_step%0d: got %0d, want %0d", i, v, dn_exp[i]); n_fail++;
            end
        end
        read_chan(0, v);
        n_checks++;
        if (v !== 12'd80) begin $display("FAIL up_final: got %0d, want 80", v); n_fail++; end
    endtask

    task automatic test_snap();
        logic [11:0] v;
        int chs[4] = '{3, 1, 2, 5};
        int exp[4] = '{500, 10, 59, 0};
        send_cmd(3, 500, 0);
        wait_frame("snap");
        n_checks++;
        if (o_time !== 4'd0) begin $display("FAIL snap_time_wrap: got %0d, want 0", o_time); n_fail++; end
        for (int i = 0; i < 4; i++) begin
            read_chan(chs[i], v);
            n_checks++;
            if (v !== 12'(exp[i])) begin
                $display("FAIL snap_ch%0d: got %0d, want %0d", chs[i], v, exp[i]); n_fail++;
            end
        end
    endtask

    task automatic test_busy();
        logic [11:0] v;
        int   n = 0;
        logic saw_fs = 1'b0;
        while (!o_cmd_ready && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (o_cmd_ready && n < 1000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_chan = 4'd4; i_cmd_target = 12'd200; i_cmd_time = 4'd2;
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin
            $display("FAIL busy_ready: got %b, want 0", o_cmd_ready); n_fail++;
        end
        n = 0;
        while (!o_cmd_ready && n < 1000) begin
            if (o_frame_start) saw_fs = 1'b1;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({o_cmd_ready, saw_fs} !== 2'b11) begin
            $display("FAIL busy_accept: ready=%b frame_before=%b, want 1 1", o_cmd_ready, saw_fs); n_fail++;
        end
        n_checks++;
        if (o_time !== 4'd1) begin $display("FAIL busy_time: got %0d, want 1", o_time); n_fail++; end
        @(negedge clk);
        i_cmd_valid = 1'b0;
        read_chan(4, v);
        n_checks++;
        if (v !== 12'd0) begin $display("FAIL busy_no_change: got %0d, want 0", v); n_fail++; end
        wait_frame("busy_next");
        read_chan(4, v);
        n_checks++;
        if (v !== 12'd200) begin $display("FAIL busy_applied: got %0d, want 200", v); n_fail++; end
    endtask

    task automatic test_overrun();
        logic [11:0] v;
        int h, f0, o0, ht;
        wait_frame("ovr_hold");
        hold = 1'b1;
        h = int'(o_time);
        ht = (h == 10) ? 0 : h + 1;
        repeat (2) @(negedge clk);
        f0 = fs_cnt;
        o0 = ovr_cnt;
        read_chan(2, v);
        n_checks++;
        if (v !== 12'd80) begin $display("FAIL wrap_final: got %0d, want 80", v); n_fail++; end
        repeat (2 * TICK + 20) @(negedge clk);
        n_checks++;
        if (ovr_cnt - o0 !== 1) begin
            $display("FAIL overrun_pulses: got %0d, want 1", ovr_cnt - o0); n_fail++;
        end
        n_checks++;
        if (fs_cnt !== f0) begin
            $display("FAIL frames_during_hold: got %0d, want 0", fs_cnt - f0); n_fail++;
        end
        hold = 1'b0;
        wait_frame("ovr_extra");
        n_checks++;
        if (o_time !== TW'(ht)) begin
            $display("FAIL extra_time: got %0d, want %0d", o_time, ht); n_fail++;
        end
        repeat (120) @(negedge clk);
        n_checks++;
        if ({fs_cnt - f0, ovr_cnt - o0} !== {32'd1, 32'd1}) begin
            $display("FAIL extra_frames: got %0d frames %0d overruns, want 1 1", fs_cnt - f0, ovr_cnt - o0);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_div();
        logic [11:0] v;
        int n = 0;
        int f0;
        send_cmd(5, 1000, 10);
        while (o_cmd_ready && n < 1000) begin @(negedge clk); n++; end
        repeat (13) @(negedge clk);
        f0 = fs_cnt;
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_time, o_cmd_ready, o_rd_data} !== {4'd0, 1'b1, 12'd0}) begin
            $display("FAIL rst_mid: got t=%0d rdy=%b rd=%0d, want 0 1 0", o_time, o_cmd_ready, o_rd_data);
            n_fail++;
        end
        for (int c = 0; c < 12; c++) begin
            read_chan(c, v);
            n_checks++;
            if (v !== 12'd0) begin $display("FAIL rst_ch%0d: got %0d, want 0", c, v); n_fail++; end
        end
        repeat (250) @(negedge clk);
        n_checks++;
        if (fs_cnt !== f0) begin
            $display("FAIL rst_no_frame: got %0d pulses, want 0", fs_cnt - f0); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_snap_setup();
        test_up_wrap();
        test_down_ramp();
        test_snap();
        test_busy();
        test_overrun();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
